// File: rtl/data_sram_responder_if.sv
// Data-SRAM request/response bundle between a requester (master) and the responder (slave).
// Latency: none, wires only.
// Backpressure: addr_ok from the slave gates request acceptance; data_ok marks one completed response.
interface data_sram_responder_if;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );

  modport slave (
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );
endinterface

// File: rtl/data_sram_responder.sv
// Word-wide SRAM model answering data_sram requests through a 2-entry in-order response queue.
// Latency: data_ok at least LAT cycles after acceptance (exactly LAT unless jitter is enabled).
// Backpressure: addr_ok = (outstanding < 2) from registered count only; optional DATA_SRAM_RSP_JITTER_EN stalls responses.
module data_sram_responder #(
  parameter int ADDR_WORDS = 256,
  parameter int LAT        = 1
) (
  input logic                  clk,
  input logic                  resetn,
  data_sram_responder_if.slave bus
);
  localparam int AW = $clog2(ADDR_WORDS);

  typedef struct packed {
    logic        wr;
    logic [31:0] rdata;
    logic [2:0]  age;
  } entry_t;

  // Backing store; deliberately not reset so contents survive a reset pulse.
  logic [31:0] mem [ADDR_WORDS];

  entry_t      q   [2];
  entry_t      q_n [2];
  entry_t      new_entry;
  logic [1:0]  cnt;
  logic [1:0]  cnt_n;
  logic        accept;
  logic        eligible;
  logic        pop;
  logic [AW-1:0] idx;

  // Size and the aliased/sub-word address bits carry no meaning for the store.
  logic unused_bits;
  assign unused_bits = &{1'b0, bus.data_sram_size, bus.data_sram_addr[31:AW+2],
                         bus.data_sram_addr[1:0]};

  assign idx                   = bus.data_sram_addr[AW+1:2];
  assign bus.data_sram_addr_ok = (cnt < 2'd2);
  assign accept                = bus.data_sram_req & bus.data_sram_addr_ok;
  // Age counts cycles since the accept cycle, so the head is due once age reaches LAT.
  assign eligible              = (cnt != 2'd0) && (q[0].age >= 3'(LAT));

`ifdef DATA_SRAM_RSP_JITTER_EN
  logic [7:0] lfsr;

  // Maximal 8-bit LFSR (x^8+x^6+x^5+x^4+1); bit 0 high holds back a due response.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr <= 8'h5A;
    else         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign pop = eligible & ~lfsr[0];
`else
  assign pop = eligible;
`endif

  assign bus.data_sram_data_ok = pop;
  assign bus.data_sram_rdata   = (pop && !q[0].wr) ? q[0].rdata : 32'd0;

  // Byte-lane write commit at the acceptance edge.
  always_ff @(posedge clk) begin
    if (accept && resetn && bus.data_sram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.data_sram_wstrb[b]) mem[idx][8*b +: 8] <= bus.data_sram_wdata[8*b +: 8];
      end
    end
  end

  // New entry snapshots the stored word now; it is already one cycle old when first visible.
  always_comb begin
    new_entry       = '0;
    new_entry.wr    = bus.data_sram_wr;
    new_entry.rdata = bus.data_sram_wr ? 32'd0 : mem[idx];
    new_entry.age   = 3'd1;
  end

  // Queue next state: age everything, pop the head, then append behind what remains.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      q_n[i] = q[i];
      if (q[i].age != 3'd7) q_n[i].age = q[i].age + 3'd1;
    end
    cnt_n = cnt;
    if (pop) begin
      q_n[0] = q_n[1];
      cnt_n  = cnt - 2'd1;
    end
    if (accept) begin
      q_n[cnt_n[0]] = new_entry;
      cnt_n         = cnt_n + 2'd1;
    end
  end

  // Queue state register; reset drops all outstanding requests.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt  <= 2'd0;
      q[0] <= '0;
      q[1] <= '0;
    end else begin
      cnt  <= cnt_n;
      q[0] <= q_n[0];
      q[1] <= q_n[1];
    end
  end
endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: instance 0 with LAT=1, instance 1 with LAT=3, both 256 words.
// A cycle-stamped request list model predicts addr_ok/data_ok/rdata every cycle.
// Directed scenarios add literal checks on logged response data and timing.
module tb_data_sram_responder;
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic [1:0]  req, wr, aok, dok;
  logic [3:0]  strb  [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rd    [2];

  data_sram_responder_if bus0 ();
  data_sram_responder_if bus1 ();

  assign bus0.data_sram_req   = req[0];
  assign bus0.data_sram_wr    = wr[0];
  assign bus0.data_sram_size  = 2'd2;
  assign bus0.data_sram_wstrb = strb[0];
  assign bus0.data_sram_addr  = addr[0];
  assign bus0.data_sram_wdata = wdata[0];
  assign aok[0] = bus0.data_sram_addr_ok;
  assign dok[0] = bus0.data_sram_data_ok;
  assign rd[0]  = bus0.data_sram_rdata;

  assign bus1.data_sram_req   = req[1];
  assign bus1.data_sram_wr    = wr[1];
  assign bus1.data_sram_size  = 2'd2;
  assign bus1.data_sram_wstrb = strb[1];
  assign bus1.data_sram_addr  = addr[1];
  assign bus1.data_sram_wdata = wdata[1];
  assign aok[1] = bus1.data_sram_addr_ok;
  assign dok[1] = bus1.data_sram_data_ok;
  assign rd[1]  = bus1.data_sram_rdata;

  data_sram_responder #(.ADDR_WORDS(256), .LAT(1)) dut0 (.clk(clk), .resetn(resetn), .bus(bus0));
  data_sram_responder #(.ADDR_WORDS(256), .LAT(3)) dut1 (.clk(clk), .resetn(resetn), .bus(bus1));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Model: memory image with known flags plus an ordered list of pending responses.
  logic [31:0] mm [2][256];
  logic        mk [2][256];
  logic        m_wr [2][2];
  logic [31:0] m_rd [2][2];
  logic        m_kn [2][2];
  int          m_acc [2][2];
  int          m_cnt [2];

  // Logs of what the DUTs actually did, for literal checks.
  int          rsp_n [2];
  int          rsp_cyc [2][64];
  logic [31:0] rsp_dat [2][64];
  int          acc_n [2];
  int          acc_cyc [2][64];

  logic        e_aok, e_dok;
  logic [31:0] e_rd;
  int          wi;

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; rsp_n[k] = 0; acc_n[k] = 0;
      for (int i = 0; i < 256; i++) begin mm[k][i] = 32'd0; mk[k][i] = 1'b0; end
    end
  end

  // Compare and model-advance, once per cycle away from the rising edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (!resetn) begin
        m_cnt[k] = 0;
        check($sformatf("reset addr_ok dut%0d", k), {31'd0, aok[k]}, 32'd1);
        check($sformatf("reset data_ok dut%0d", k), {31'd0, dok[k]}, 32'd0);
        check($sformatf("reset rdata dut%0d", k), rd[k], 32'd0);
      end else begin
        e_aok = (m_cnt[k] < 2);
        e_dok = (m_cnt[k] > 0) && (cyc - m_acc[k][0] >= lat_of(k));
        e_rd  = (e_dok && !m_wr[k][0]) ? m_rd[k][0] : 32'd0;
        check($sformatf("addr_ok dut%0d cyc%0d", k, cyc), {31'd0, aok[k]}, {31'd0, e_aok});
        check($sformatf("data_ok dut%0d cyc%0d", k, cyc), {31'd0, dok[k]}, {31'd0, e_dok});
        if (!(e_dok && !m_wr[k][0] && !m_kn[k][0]))
          check($sformatf("rdata dut%0d cyc%0d", k, cyc), rd[k], e_rd);
        if (dok[k]) begin
          if (rsp_n[k] < 64) begin rsp_cyc[k][rsp_n[k]] = cyc; rsp_dat[k][rsp_n[k]] = rd[k]; end
          rsp_n[k]++;
        end
        if (req[k] && aok[k]) begin
          if (acc_n[k] < 64) acc_cyc[k][acc_n[k]] = cyc;
          acc_n[k]++;
        end
        if (e_dok) begin
          m_wr[k][0] = m_wr[k][1]; m_rd[k][0] = m_rd[k][1];
          m_kn[k][0] = m_kn[k][1]; m_acc[k][0] = m_acc[k][1];
          m_cnt[k]--;
        end
        if (req[k] && e_aok) begin
          wi = int'(addr[k][9:2]);
          if (wr[k]) begin
            for (int b = 0; b < 4; b++)
              if (strb[k][b]) mm[k][wi][8*b +: 8] = wdata[k][8*b +: 8];
            if (strb[k] == 4'hF) mk[k][wi] = 1'b1;
          end
          m_wr[k][m_cnt[k]]  = wr[k];
          m_rd[k][m_cnt[k]]  = wr[k] ? 32'd0 : mm[k][wi];
          m_kn[k][m_cnt[k]]  = wr[k] ? 1'b1 : mk[k][wi];
          m_acc[k][m_cnt[k]] = cyc;
          m_cnt[k]++;
        end
      end
    end
  end

  // Present a request and hold it until accepted; returns just after the accepting edge.
  task automatic issue(input int k, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    int tries;
    req[k] = 1'b1; wr[k] = w; addr[k] = a; wdata[k] = d; strb[k] = s;
    tries = 0;
    forever begin
      @(negedge clk);
      if (aok[k]) break;
      tries++;
      if (tries > 20) begin
        checks++; errors++;
        $display("FAIL accept timeout dut%0d: got no addr_ok, expected acceptance", k);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int k);
    req[k] = 1'b0; wr[k] = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int r0, a0;
    resetn = 1'b0;
    req = 2'b00; wr = 2'b00;
    for (int k = 0; k < 2; k++) begin strb[k] = 4'h0; addr[k] = 32'd0; wdata[k] = 32'd0; end
    #23 resetn = 1'b1;
    wait_cycles(2);

    // Full-word write then read.
    r0 = rsp_n[0];
    issue(0, 1'b1, 32'h10, 32'h11223344, 4'hF);
    issue(0, 1'b0, 32'h10, 32'h0, 4'hF);
    idle(0); wait_cycles(5);
    check("wr_rd response count", rsp_n[0], r0 + 2);
    check("wr_rd write rdata", rsp_dat[0][r0], 32'd0);
    check("wr_rd read rdata", rsp_dat[0][r0+1], 32'h11223344);

    // Single-lane write over zero.
    r0 = rsp_n[0];
    issue(0, 1'b1, 32'h20, 32'h0, 4'hF);
    issue(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0100);
    issue(0, 1'b0, 32'h20, 32'h0, 4'hF);
    idle(0); wait_cycles(5);
    check("strb response count", rsp_n[0], r0 + 3);
    check("strb read rdata", rsp_dat[0][r0+2], 32'h00BB0000);

    // Address aliasing above the store depth.
    r0 = rsp_n[0];
    issue(0, 1'b1, 32'h400, 32'h5, 4'hF);
    issue(0, 1'b0, 32'h000, 32'h0, 4'hF);
    idle(0); wait_cycles(5);
    check("alias read rdata", rsp_dat[0][r0+1], 32'h5);

    // LAT=1 streaming: 8 writes then 8 reads with req held high.
    for (int i = 0; i < 8; i++)
      issue(0, 1'b1, 32'(i*4), 32'h10000000 + 32'(i) * 32'h01010101, 4'hF);
    idle(0); wait_cycles(3);
    r0 = rsp_n[0]; a0 = acc_n[0];
    for (int i = 0; i < 8; i++) issue(0, 1'b0, 32'(i*4), 32'h0, 4'hF);
    idle(0); wait_cycles(5);
    check("stream response count", rsp_n[0], r0 + 8);
    check("stream accept span", acc_cyc[0][a0+7] - acc_cyc[0][a0], 7);
    check("stream response span", rsp_cyc[0][r0+7] - rsp_cyc[0][r0], 7);
    check("stream first latency", rsp_cyc[0][r0] - acc_cyc[0][a0], 1);
    for (int i = 0; i < 8; i++)
      check($sformatf("stream rdata %0d", i), rsp_dat[0][r0+i],
            32'h10000000 + 32'(i) * 32'h01010101);

    // LAT=3: queue fills after two accepts, third waits for the first response.
    issue(1, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF);
    idle(1); wait_cycles(6);
    r0 = rsp_n[1]; a0 = acc_n[1];
    issue(1, 1'b0, 32'h40, 32'h0, 4'hF);
    issue(1, 1'b0, 32'h40, 32'h0, 4'hF);
    issue(1, 1'b1, 32'h44, 32'h12345678, 4'hF);
    idle(1); wait_cycles(10);
    check("lat3 response count", rsp_n[1], r0 + 3);
    check("lat3 first latency", rsp_cyc[1][r0] - acc_cyc[1][a0], 3);
    check("lat3 second accept gap", acc_cyc[1][a0+1] - acc_cyc[1][a0], 1);
    check("lat3 third accept gap", acc_cyc[1][a0+2] - acc_cyc[1][a0+1], 3);
    check("lat3 third after first rsp", acc_cyc[1][a0+2] - rsp_cyc[1][r0], 1);
    check("lat3 read rdata", rsp_dat[1][r0], 32'hCAFEF00D);

    // Reset with two requests outstanding.
    issue(1, 1'b0, 32'h40, 32'h0, 4'hF);
    issue(1, 1'b0, 32'h40, 32'h0, 4'hF);
    idle(1);
    resetn = 1'b0;
    r0 = rsp_n[1];
    wait_cycles(2);
    #2 resetn = 1'b1;
    wait_cycles(10);
    check("reset drops responses", rsp_n[1], r0);
    check("reset addr_ok after release", {31'd0, aok[1]}, 32'd1);
    issue(1, 1'b0, 32'h40, 32'h0, 4'hF);
    idle(1); wait_cycles(6);
    check("reset response count", rsp_n[1], r0 + 1);
    check("store kept across reset", rsp_dat[1][r0], 32'hCAFEF00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_sram_responder.md
DATA_SRAM_RESPONDER -- requirements
Module: data_sram_responder

Interface
REQ-001 SHALL have parameter ADDR_WORDS, default 256, meaning backing-store depth in 32-bit words (power of two, 16..4096).
REQ-002 SHALL have parameter LAT, default 1, meaning the minimum number of cycles from request acceptance to data_ok (1..7).
REQ-003 SHALL have port clk  in  1  the single clock, rising edge.
REQ-004 SHALL have port resetn  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port data_sram_req  in  1  request valid.
REQ-006 SHALL have port data_sram_wr  in  1  1 = write, 0 = read.
REQ-007 SHALL have port data_sram_size  in  2  0 = byte, 1 = half, 2 = word; informational only.
REQ-008 SHALL have port data_sram_wstrb  in  4  byte enables for a write.
REQ-009 SHALL have port data_sram_addr  in  32  byte address.
REQ-010 SHALL have port data_sram_wdata  in  32  write data, byte lanes aligned to the address.
REQ-011 SHALL have port data_sram_addr_ok  out  1  request slot available.
REQ-012 SHALL have port data_sram_data_ok  out  1  one response completes this cycle.
REQ-013 SHALL have port data_sram_rdata  out  32  read word, valid only while data_ok is high.

Function
REQ-014 SHALL accept a request on a rising edge where req and addr_ok are both 1; no other request is accepted.
REQ-015 SHALL drive addr_ok = (outstanding count < 2), derived from registered state only and independent of req; a pop in the same cycle does not free a slot early.
REQ-016 SHALL index the store with addr[log2(ADDR_WORDS)+1:2]; higher address bits are ignored (wrap-around aliasing).
REQ-017 SHALL commit a write at the acceptance edge, updating only the byte lanes whose wstrb bit is 1; wstrb = 0 updates nothing but still produces a response.
REQ-018 SHALL capture the full read word at the acceptance edge into the queue entry, reflecting all writes accepted earlier; a read never returns data from a later write.
REQ-019 SHALL return the full 32-bit word for every read regardless of size and addr[1:0]; lane extraction belongs to the requester.
REQ-020 SHALL hold outstanding requests in a 2-entry in-order queue, each entry holding {wr, rdata, age[2:0]}.
REQ-021 SHALL set an entry's age to 0 at acceptance and increment it every following cycle, saturating at 7.
REQ-022 SHALL assert data_ok for exactly one cycle per accepted request, reads and writes alike, in acceptance order.
REQ-023 SHALL assert data_ok in any cycle where the queue is non-empty and head age >= LAT; the head pops at the end of that cycle.
REQ-024 SHALL drive rdata = head rdata while data_ok = 1 on a read response, and 0 otherwise, including on write responses.
REQ-025 SHALL, with LAT = 1 and req held high, accept and respond every cycle (throughput 1) with a constant queue count of 1.
REQ-026 SHALL, on simultaneous accept and pop, leave the count unchanged and place the new entry behind any remaining entry.
REQ-027 SHALL NOT accept the request that caused an overflow; the queue count never exceeds 2 or underflows.

Reset
REQ-028 SHALL, while resetn = 0, clear the queue count, all entry ages and the LFSR, forcing addr_ok = 1 (combinational from the cleared count), data_ok = 0 and rdata = 0.
REQ-029 SHALL discard outstanding requests when reset is asserted mid-operation; no data_ok is produced for them after release.
REQ-030 SHALL leave the backing-store contents unaffected by reset.

Configuration
REQ-031 SHALL compile a response-jitter feature under macro DATA_SRAM_RSP_JITTER_EN.
REQ-032 SHALL, with DATA_SRAM_RSP_JITTER_EN defined, run an 8-bit maximal LFSR (x^8+x^6+x^5+x^4+1, reset seed 8'h5A) stepping every cycle and suppress data_ok in any cycle where LFSR bit 0 = 1; ages continue to saturate.
REQ-033 SHALL, without DATA_SRAM_RSP_JITTER_EN, omit the LFSR entirely and respond exactly at the first eligible cycle per REQ-023.

Verification
REQ-034 SHALL cover: write 0x11223344 to addr 0x10 with wstrb 4'hF, then read 0x10 -> data_ok once per request, read rdata = 0x11223344.
REQ-035 SHALL cover: write 0xAABBCCDD to 0x20 with wstrb 4'b0100 over prior 0, then read -> rdata = 0x00BB0000.
REQ-036 SHALL cover: LAT = 1, req held high for 8 reads -> 8 consecutive data_ok cycles, addr_ok never 0.
REQ-037 SHALL cover: LAT = 3, 3 back-to-back requests -> addr_ok drops after the 2nd accept, 3rd accepted only after the first data_ok, first data_ok 3 cycles after accept.
REQ-038 SHALL cover: ADDR_WORDS = 256, write 0x5 to 0x400, read 0x000 -> rdata = 0x5 (alias).
REQ-039 SHALL cover: resetn pulsed low with 2 requests outstanding -> no data_ok afterwards, addr_ok = 1, store contents preserved.
